// File: rtl/servo_slew_sequencer_pkg.sv
// Shared servo definitions: widths, reset position, FSM states and the
// saturating step helper that moves a position toward its target.
package servo_pkg;

    localparam int POS_W  = 8;
    localparam int STEP_W = 4;

    localparam logic [POS_W-1:0] DEFAULT_POS = 8'd128;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } state_e;

    // Move p toward t by s, clamped at t. Done in POS_W+1 bits so the
    // add/subtract can never wrap; a zero step leaves p unchanged.
    function automatic logic [POS_W-1:0] sat_step(
        input logic [POS_W-1:0]  p,
        input logic [POS_W-1:0]  t,
        input logic [STEP_W-1:0] s
    );
        logic [POS_W:0] s_ext;
        logic [POS_W:0] sum;
        logic [POS_W:0] diff;
        s_ext = {{(POS_W + 1 - STEP_W){1'b0}}, s};
        sum   = {1'b0, p} + s_ext;
        diff  = {1'b0, p} - s_ext;
        if (p < t) begin
            return (sum > {1'b0, t}) ? t : sum[POS_W-1:0];
        end else if (p > t) begin
            return (diff[POS_W] || (diff[POS_W-1:0] < t)) ? t : diff[POS_W-1:0];
        end
        return p;
    endfunction

endpackage

// File: rtl/servo_slew_sequencer_if.sv
// Command port of the servo slew sequencer.
//
// Handshake: the master drives cmd_valid with cmd_ch/cmd_target/cmd_step
// stable; a transfer happens on each rising clk edge where cmd_valid and
// cmd_ready are both 1. The master must hold valid and payload until that
// edge. cmd_ready does not depend on cmd_valid.
interface servo_slew_sequencer_if #(
    parameter int NUM_CH = 4
);
    import servo_pkg::*;

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [CH_W-1:0]   cmd_ch;
    logic [POS_W-1:0]  cmd_target;
    logic [STEP_W-1:0] cmd_step;

    modport master (
        output cmd_valid,
        output cmd_ch,
        output cmd_target,
        output cmd_step,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_ch,
        input  cmd_target,
        input  cmd_step,
        output cmd_ready
    );

endinterface

// File: rtl/servo_slew_sequencer_frame_timer.sv
// Free-running frame counter; emits a registered one-cycle pulse each time
// the counter wraps, so it lines up with the PWM period.
module servo_frame_timer #(
    parameter int FRAME_BITS = 20
) (
    input  logic clk,
    input  logic rst_n,
    output logic frame_tick
);

    logic [FRAME_BITS-1:0] cnt;

    // Count every cycle; pulse in the cycle after the counter reads all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt + 1'b1;
            frame_tick <= &cnt;
        end
    end

endmodule

// File: rtl/servo_slew_sequencer.sv
// Servo slew sequencer: holds per-channel target/step/position registers,
// accepts target commands while idle and, once per frame, sweeps all
// channels one per cycle moving each position toward its target.
module servo_slew_sequencer #(
    parameter int                          NUM_CH      = 4,
    parameter int                          FRAME_BITS  = 20,
    parameter logic [servo_pkg::POS_W-1:0] DEFAULT_POS = servo_pkg::DEFAULT_POS
) (
    input  logic                                clk,
    input  logic                                rst_n,
    servo_slew_sequencer_if.slave               cmd,
    output logic [NUM_CH*servo_pkg::POS_W-1:0]  pos,
    output logic [NUM_CH-1:0]                   busy,
    output logic                                frame_tick,
    output logic                                cmd_err,
    output servo_pkg::state_e                   fsm_state
);
    import servo_pkg::*;

    localparam int              CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W:0]   NUM_CH_L = (CH_W + 1)'(NUM_CH);
    localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);

    state_e            state_q;
    logic [CH_W-1:0]   idx_q;
    logic              ready_q;

    logic [POS_W-1:0]  pos_q    [NUM_CH];
    logic [POS_W-1:0]  tgt_q    [NUM_CH];
    logic [STEP_W-1:0] step_q   [NUM_CH];
    logic [POS_W-1:0]  pos_nxt  [NUM_CH];
    logic [POS_W-1:0]  tgt_nxt  [NUM_CH];
    logic [STEP_W-1:0] step_nxt [NUM_CH];
    logic [NUM_CH-1:0] busy_nxt;
    logic              err_nxt;

    logic              accept;
    logic              ch_ok;

    servo_frame_timer #(
        .FRAME_BITS (FRAME_BITS)
    ) u_frame_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick)
    );

    assign accept        = cmd.cmd_valid & ready_q;
    assign ch_ok         = ({1'b0, cmd.cmd_ch} < NUM_CH_L);
    assign cmd.cmd_ready = ready_q;
    assign fsm_state     = state_q;

    // Next register contents: command write first, then the one-channel
    // frame update; busy follows the values being written this edge.
    always_comb begin
        tgt_nxt  = tgt_q;
        step_nxt = step_q;
        pos_nxt  = pos_q;
        err_nxt  = 1'b0;
        busy_nxt = '0;
        if (accept) begin
            if (ch_ok) begin
                tgt_nxt[cmd.cmd_ch]  = cmd.cmd_target;
                step_nxt[cmd.cmd_ch] = cmd.cmd_step;
                if (cmd.cmd_step == '0) begin
                    pos_nxt[cmd.cmd_ch] = cmd.cmd_target;
                end
            end else begin
                err_nxt = 1'b1;
            end
        end
        if (state_q == UPDATE) begin
            pos_nxt[idx_q] = sat_step(pos_q[idx_q], tgt_q[idx_q], step_q[idx_q]);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            busy_nxt[i] = (pos_nxt[i] != tgt_nxt[i]);
        end
    end

    // Sequencer FSM plus channel register bank; ready is registered with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ready_q <= 1'b1;
            cmd_err <= 1'b0;
            busy    <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                pos_q[i]  <= DEFAULT_POS;
                tgt_q[i]  <= DEFAULT_POS;
                step_q[i] <= '0;
            end
        end else begin
            pos_q   <= pos_nxt;
            tgt_q   <= tgt_nxt;
            step_q  <= step_nxt;
            busy    <= busy_nxt;
            cmd_err <= err_nxt;
            case (state_q)
                IDLE: begin
                    if (frame_tick) begin
                        state_q <= UPDATE;
                        idx_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end
                UPDATE: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Flatten the position registers onto the servo value bus.
    always_comb begin
        pos = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pos[i*POS_W +: POS_W] = pos_q[i];
        end
    end

endmodule
